product_accumulator: RTL

//   Sequential consumer of the 4-bit multiplier's 8-bit product (y). Sums a frame
//   of N products and presents the frame total with a valid/ready handshake.

---
 rtl/product_accumulator.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/product_accumulator.sv
// product_accumulator
//
// Sums a frame of N unsigned products, which normally come straight from the
// 4-bit multiplier. The frame total is then offered downstream with a
// valid/ready handshake. This is the accumulate half of a small MAC datapath.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous, active-high reset; drops any partial frame
//                  and any held result
//   clr_i          synchronous frame abort; discards the partial sum. It is
//                  ignored while a result is held.
//   in_valid_i     in_product_i carries a product this cycle
//   in_ready_o     a product is accepted this cycle; combinational (state & ~clr_i)
//   in_product_i   unsigned product, zero-extended to AW
//   out_valid_o    out_sum_o / out_ovf_o hold a completed frame
//   out_ready_i    downstream takes the held result this cycle
//   out_sum_o      frame total modulo 2^AW; registered
//   out_ovf_o      frame total exceeded 2^AW-1 at some point in the frame; registered
//
// Parameters
//   PW  product width
//   N   products per frame, 1..255
//   AW  accumulator/result width, AW >= PW

module product_accumulator #(
    parameter int unsigned PW = 8,
    parameter int unsigned N  = 4,
    parameter int unsigned AW = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [PW-1:0] in_product_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [AW-1:0] out_sum_o,
    output logic          out_ovf_o
);

    // Frame counter only has to reach N-1. For N=1 it stays at 0.
    localparam int unsigned  CW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(N - 1);

    // Reject illegal parameterisations at elaboration time.
    if (AW < PW) begin : gen_bad_aw
        $error("product_accumulator: AW must be >= PW");
    end
    if (N < 1 || N > 255) begin : gen_bad_n
        $error("product_accumulator: N must be in 1..255");
    end

    typedef enum logic [0:0] {
        StAcc,
        StHold
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] sum_q, sum_d;
    logic          out_ovf_q, out_ovf_d;

    logic          accept;
    logic          last;
    logic [AW:0]   add_full;

    // Datapath
    // Bit AW of the widened add is the carry that marks a frame overflow.
    assign add_full = {1'b0, acc_q} + (AW + 1)'(in_product_i);
    assign last     = (cnt_q == LastCnt);

    // Handshake
    // A clr_i in the accumulate state also blocks the product offered
    // in the same cycle.
    assign in_ready_o = (state_q == StAcc) && !clr_i;
    assign accept     = in_valid_i && in_ready_o;

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        sum_d     = sum_q;
        out_ovf_d = out_ovf_q;

        unique case (state_q)
            StAcc: begin
                if (clr_i) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (accept) begin
                    if (last) begin
                        // Final product: publish the total and restart the
                        // accumulator in the same edge.
                        sum_d     = add_full[AW-1:0];
                        out_ovf_d = ovf_q | add_full[AW];
                        acc_d     = '0;
                        cnt_d     = '0;
                        ovf_d     = 1'b0;
                        state_d   = StHold;
                    end else begin
                        acc_d = add_full[AW-1:0];
                        ovf_d = ovf_q | add_full[AW];
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StHold: begin
                // The result stays until it is taken. In the handoff cycle
                // in_ready_o is still low, so no product is accepted.
                if (out_ready_i) begin
                    state_d = StAcc;
                end
            end
            default: begin
                state_d = StAcc;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StAcc;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            sum_q     <= sum_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    // Outputs
    // out_valid_o comes directly from the state register, so it is registered too.
    assign out_valid_o = (state_q == StHold);
    assign out_sum_o   = sum_q;
    assign out_ovf_o   = out_ovf_q;

endmodule
